br_pc_ctrl: RTL and testbench

- Branch-resolution and PC-update block for the pipelined core. It sits directly downstream of brc in the EX stage.
- It decodes the EX-stage branch/jump, drives brc's signed/unsigned select, and consumes brc's less/equal flags to make the taken decision.
- It computes the target, owns the fetch PC register, and issues redirect and flush to IF/ID and ID/EX.
- It also keeps saturating branch statistics counters.

---
 rtl/br_pkg.sv | 16 +
 rtl/br_cond.sv | 29 ++
 rtl/br_pc_ctrl.sv | 110 +++++++++++
 tb/tb_br_pc_ctrl.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/br_pkg.sv
// Shared types and constants for branch resolution and PC control.
package br_pkg;

  typedef logic [31:0] addr_t;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam addr_t DEF_RESET_PC = 32'h0000_0000;
  localparam addr_t DEF_TRAP_VEC = 32'h0000_0100;

endpackage

// File: rtl/br_cond.sv
// Branch condition decode: funct3 plus brc flags to taken condition and compare mode.
module br_cond
  import br_pkg::*;
(
  input  logic [2:0] funct3_i,
  input  logic       less_i,
  input  logic       equal_i,
  output logic       cond_o,
  output logic       br_un_o,
  output logic       illegal_o
);

  // Decode funct3; br_un_o = 1 selects the signed compare in brc.
  always_comb begin
    cond_o    = 1'b0;
    br_un_o   = 1'b0;
    illegal_o = 1'b0;
    case (funct3_i)
      F3_BEQ:  begin cond_o = equal_i;  br_un_o = 1'b1; end
      F3_BNE:  begin cond_o = ~equal_i; br_un_o = 1'b1; end
      F3_BLT:  begin cond_o = less_i;   br_un_o = 1'b1; end
      F3_BGE:  begin cond_o = ~less_i;  br_un_o = 1'b1; end
      F3_BLTU: cond_o = less_i;
      F3_BGEU: cond_o = ~less_i;
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/br_pc_ctrl.sv
// EX-stage branch resolution, fetch PC register, redirect/flush and branch statistics.
module br_pc_ctrl
  import br_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEF_RESET_PC,
  parameter logic [31:0] TRAP_VEC = DEF_TRAP_VEC,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_stall,
  input  logic             i_ex_valid,
  input  logic [31:0]      i_ex_pc,
  input  logic             i_ex_is_br,
  input  logic             i_ex_is_jal,
  input  logic             i_ex_is_jalr,
  input  logic [2:0]       i_ex_funct3,
  input  logic [31:0]      i_ex_imm,
  input  logic [31:0]      i_rs1_data,
  input  logic             i_br_less,
  input  logic             i_br_equal,
  output logic             o_br_un,
  output logic [31:0]      o_pc,
  output logic             o_redirect,
  output logic             o_flush_if,
  output logic             o_flush_id,
  output logic             o_misalign,
  output logic             o_illegal_br,
  output logic [CNT_W-1:0] o_cnt_branch,
  output logic [CNT_W-1:0] o_cnt_taken
);

  logic             cond;
  logic             br_un_raw;
  logic             illegal_raw;
  logic             is_jump;
  logic             br_eff;
  logic             br_legal;
  logic             taken;
  logic             misalign;
  addr_t            target;
  addr_t            eff_target;
  addr_t            pc_q, pc_d;
  logic [CNT_W-1:0] cnt_branch_q, cnt_branch_d;
  logic [CNT_W-1:0] cnt_taken_q, cnt_taken_d;

  br_cond u_br_cond (
    .funct3_i  (i_ex_funct3),
    .less_i    (i_br_less),
    .equal_i   (i_br_equal),
    .cond_o    (cond),
    .br_un_o   (br_un_raw),
    .illegal_o (illegal_raw)
  );

  // Taken decision and target; a jump flag masks any branch flag on the same instruction.
  always_comb begin
    is_jump    = i_ex_is_jal | i_ex_is_jalr;
    br_eff     = i_ex_valid & i_ex_is_br & ~is_jump;
    br_legal   = br_eff & ~illegal_raw;
    taken      = (i_ex_valid & is_jump) | (br_legal & cond);
    target     = i_ex_is_jalr ? ((i_rs1_data + i_ex_imm) & ~32'h1) : (i_ex_pc + i_ex_imm);
    misalign   = taken & (target[1:0] != 2'b00);
    eff_target = misalign ? TRAP_VEC : target;
  end

  // Combinational outputs, all forced low for a bubble.
  always_comb begin
    o_br_un      = i_ex_valid & br_un_raw;
    o_redirect   = taken;
    o_flush_if   = taken;
    o_flush_id   = taken;
    o_misalign   = misalign;
    o_illegal_br = br_eff & illegal_raw;
  end

  // PC next-state: redirect beats stall; counters saturate and ignore stall.
  always_comb begin
    pc_d         = pc_q + 32'd4;
    cnt_branch_d = cnt_branch_q;
    cnt_taken_d  = cnt_taken_q;
    if (taken) begin
      pc_d = eff_target;
    end else if (i_stall) begin
      pc_d = pc_q;
    end
    if (br_legal) begin
      if (cnt_branch_q != '1) cnt_branch_d = cnt_branch_q + CNT_W'(1);
      if (cond && (cnt_taken_q != '1)) cnt_taken_d = cnt_taken_q + CNT_W'(1);
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pc_q         <= RESET_PC;
      cnt_branch_q <= '0;
      cnt_taken_q  <= '0;
    end else begin
      pc_q         <= pc_d;
      cnt_branch_q <= cnt_branch_d;
      cnt_taken_q  <= cnt_taken_d;
    end
  end

  assign o_pc         = pc_q;
  assign o_cnt_branch = cnt_branch_q;
  assign o_cnt_taken  = cnt_taken_q;

endmodule

// File: tb/tb_br_pc_ctrl.sv
// Scoreboard bench for br_pc_ctrl: a spec-level model pushes expectations per cycle.
module tb_br_pc_ctrl;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] TRAP   = 32'h0000_0100;
  localparam int          CW     = 16;
  localparam logic [CW-1:0] SAT  = '1;

  logic          clk = 1'b0;
  logic          rst, stall, valid, is_br, is_jal, is_jalr, less, equal;
  logic [2:0]    funct3;
  logic [31:0]   ex_pc, imm, rs1;
  logic          br_un, redirect, flush_if, flush_id, misalign, illegal_br;
  logic [31:0]   pc;
  logic [CW-1:0] cnt_branch, cnt_taken;

  br_pc_ctrl dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_stall      (stall),
    .i_ex_valid   (valid),
    .i_ex_pc      (ex_pc),
    .i_ex_is_br   (is_br),
    .i_ex_is_jal  (is_jal),
    .i_ex_is_jalr (is_jalr),
    .i_ex_funct3  (funct3),
    .i_ex_imm     (imm),
    .i_rs1_data   (rs1),
    .i_br_less    (less),
    .i_br_equal   (equal),
    .o_br_un      (br_un),
    .o_pc         (pc),
    .o_redirect   (redirect),
    .o_flush_if   (flush_if),
    .o_flush_id   (flush_id),
    .o_misalign   (misalign),
    .o_illegal_br (illegal_br),
    .o_cnt_branch (cnt_branch),
    .o_cnt_taken  (cnt_taken)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]   pc;
    logic          redir;
    logic          fif;
    logic          fid;
    logic          un;
    logic          mis;
    logic          ill;
    logic [CW-1:0] cb;
    logic [CW-1:0] ct;
  } exp_t;

  exp_t          exp_q[$];
  exp_t          cur, obs;
  int            vectors = 0;
  int            errors  = 0;
  logic [31:0]   m_pc;
  logic [CW-1:0] m_cb, m_ct;

  // Drive one EX cycle at the falling edge and push the model's expectation.
  task automatic step(input logic r, input logic st, input logic v, input logic b,
                      input logic j, input logic jr, input logic [2:0] f3,
                      input logic [31:0] p, input logic [31:0] im, input logic [31:0] s1,
                      input logic ls, input logic eq);
    logic c, il, un, bf, tk, mi;
    logic [31:0] tg;
    exp_t e;
    @(negedge clk);
    rst = r; stall = st; valid = v; is_br = b; is_jal = j; is_jalr = jr;
    funct3 = f3; ex_pc = p; imm = im; rs1 = s1; less = ls; equal = eq;
    case (f3)
      3'b000: c = eq;
      3'b001: c = !eq;
      3'b100, 3'b110: c = ls;
      3'b101, 3'b111: c = !ls;
      default: c = 1'b0;
    endcase
    il = (f3 == 3'b010) || (f3 == 3'b011);
    un = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b100) || (f3 == 3'b101);
    bf = v && b && !j && !jr;
    tk = (v && (j || jr)) || (bf && c && !il);
    tg = jr ? ((s1 + im) & 32'hFFFF_FFFE) : (p + im);
    mi = tk && (tg[1:0] != 2'b00);
    e.redir = tk; e.fif = tk; e.fid = tk;
    e.un = v && un; e.mis = mi; e.ill = bf && il;
    if (r) begin
      m_pc = RST_PC; m_cb = '0; m_ct = '0;
    end else begin
      if (tk) m_pc = mi ? TRAP : tg;
      else if (!st) m_pc = m_pc + 32'd4;
      if (bf && !il) begin
        if (m_cb != SAT) m_cb = m_cb + 1'b1;
        if (c && m_ct != SAT) m_ct = m_ct + 1'b1;
      end
    end
    e.pc = m_pc; e.cb = m_cb; e.ct = m_ct;
    exp_q.push_back(e);
  endtask

  // Capture combinational outputs mid-cycle and registered state after the edge; pop expectation.
  task automatic tick();
    #1;
    obs.redir = redirect; obs.fif = flush_if; obs.fid = flush_id;
    obs.un = br_un; obs.mis = misalign; obs.ill = illegal_br;
    @(posedge clk);
    #1;
    obs.pc = pc; obs.cb = cnt_branch; obs.ct = cnt_taken;
    vectors++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty got 0 entries want 1");
    end else begin
      cur = exp_q.pop_front();
    end
  endtask

  task automatic test_reset();
    step(1, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0); tick();
    vectors++; if (obs.pc !== RST_PC) begin errors++;
      $display("FAIL reset_pc got %h want %h", obs.pc, RST_PC); end
    vectors++; if (obs.cb !== '0 || obs.ct !== '0) begin errors++;
      $display("FAIL reset_cnt got %h/%h want 0/0", obs.cb, obs.ct); end
    vectors++; if (obs.redir !== 1'b0) begin errors++;
      $display("FAIL reset_redirect got %b want 0", obs.redir); end
  endtask

  task automatic test_sequential();
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0); tick();
      vectors++; if (obs.pc !== cur.pc) begin errors++;
        $display("FAIL seq_pc[%0d] got %h want %h", i, obs.pc, cur.pc); end
    end
    vectors++; if (obs.pc !== 32'hC) begin errors++;
      $display("FAIL seq_final got %h want 0000000c", obs.pc); end
    vectors++; if (obs.cb !== cur.cb || obs.ct !== cur.ct) begin errors++;
      $display("FAIL seq_cnt got %h/%h want %h/%h", obs.cb, obs.ct, cur.cb, cur.ct); end
  endtask

  task automatic test_blt_taken();
    step(0, 0, 1, 1, 0, 0, 3'b100, 32'h100, 32'h20, 0, 1, 0); tick();
    vectors++; if (obs.un !== cur.un) begin errors++;
      $display("FAIL blt_br_un got %b want %b", obs.un, cur.un); end
    vectors++; if ({obs.redir, obs.fif, obs.fid} !== {3{cur.redir}}) begin errors++;
      $display("FAIL blt_redir got %b%b%b want %b", obs.redir, obs.fif, obs.fid, cur.redir); end
    vectors++; if (obs.pc !== cur.pc) begin errors++;
      $display("FAIL blt_pc got %h want %h", obs.pc, cur.pc); end
    vectors++; if (obs.cb !== cur.cb || obs.ct !== cur.ct) begin errors++;
      $display("FAIL blt_cnt got %h/%h want %h/%h", obs.cb, obs.ct, cur.cb, cur.ct); end
  endtask

  task automatic test_bgeu_not_taken();
    step(0, 0, 1, 1, 0, 0, 3'b111, 32'h120, 32'h40, 0, 1, 0); tick();
    vectors++; if (obs.un !== cur.un || obs.redir !== cur.redir) begin errors++;
      $display("FAIL bgeu_un_redir got %b/%b want %b/%b", obs.un, obs.redir, cur.un, cur.redir);
    end
    vectors++; if (obs.pc !== cur.pc) begin errors++;
      $display("FAIL bgeu_pc got %h want %h", obs.pc, cur.pc); end
    vectors++; if (obs.cb !== cur.cb || obs.ct !== cur.ct) begin errors++;
      $display("FAIL bgeu_cnt got %h/%h want %h/%h", obs.cb, obs.ct, cur.cb, cur.ct); end
  endtask

  task automatic test_jalr_misalign();
    step(0, 0, 1, 0, 0, 1, 3'b000, 32'h124, 0, 32'h203, 0, 0); tick();
    vectors++; if (obs.mis !== cur.mis || obs.redir !== cur.redir) begin errors++;
      $display("FAIL jalr_mis got %b/%b want %b/%b", obs.mis, obs.redir, cur.mis, cur.redir); end
    vectors++; if (obs.pc !== cur.pc) begin errors++;
      $display("FAIL jalr_trap_pc got %h want %h", obs.pc, cur.pc); end
  endtask

  task automatic test_stall();
    step(0, 1, 1, 1, 0, 0, 3'b000, 32'h40, 32'hFFFF_FFF8, 0, 0, 1); tick();
    vectors++; if (obs.pc !== cur.pc) begin errors++;
      $display("FAIL stall_redirect_pc got %h want %h", obs.pc, cur.pc); end
    step(0, 1, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0); tick();
    vectors++; if (obs.pc !== cur.pc) begin errors++;
      $display("FAIL stall_hold_pc got %h want %h", obs.pc, cur.pc); end
  endtask

  task automatic test_illegal();
    for (int f = 2; f < 4; f++) begin
      step(0, 0, 1, 1, 0, 0, 3'(f), 32'h38, 32'h10, 0, 0, 1); tick();
      vectors++; if (obs.ill !== cur.ill || obs.redir !== cur.redir) begin errors++;
        $display("FAIL illegal_f3_%0d got %b/%b want %b/%b", f, obs.ill, obs.redir,
                 cur.ill, cur.redir); end
      vectors++; if (obs.cb !== cur.cb || obs.pc !== cur.pc) begin errors++;
        $display("FAIL illegal_state got %h/%h want %h/%h", obs.cb, obs.pc, cur.cb, cur.pc); end
    end
  endtask

  task automatic test_valid_low();
    step(0, 0, 0, 1, 1, 0, 3'b000, 32'h80, 32'h8, 0, 1, 1); tick();
    vectors++; if ({obs.un, obs.redir, obs.mis, obs.ill} !== 4'b0000) begin errors++;
      $display("FAIL bubble_outs got %b%b%b%b want 0000", obs.un, obs.redir, obs.mis, obs.ill);
    end
    vectors++; if (obs.pc !== cur.pc || obs.cb !== cur.cb) begin errors++;
      $display("FAIL bubble_state got %h/%h want %h/%h", obs.pc, obs.cb, cur.pc, cur.cb); end
  endtask

  task automatic test_back_to_back();
    step(0, 0, 1, 1, 1, 0, 3'b000, 32'h0, 32'hFFFF_FFFC, 0, 0, 1); tick();
    vectors++; if (obs.pc !== 32'hFFFF_FFFC || obs.cb !== cur.cb) begin errors++;
      $display("FAIL jal_prio got %h/%h want fffffffc/%h", obs.pc, obs.cb, cur.cb); end
    step(0, 0, 1, 0, 0, 1, 3'b000, 32'h8, 32'h11, 32'h1000, 0, 0); tick();
    vectors++; if (obs.redir !== 1'b1 || obs.pc !== cur.pc) begin errors++;
      $display("FAIL b2b_jalr got %b/%h want 1/%h", obs.redir, obs.pc, cur.pc); end
    step(0, 0, 1, 0, 1, 0, 3'b000, 32'h0, 32'hFFFF_FFFC, 0, 0, 0); tick();
    step(0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0); tick();
    vectors++; if (obs.pc !== 32'h0) begin errors++;
      $display("FAIL pc_wrap got %h want 00000000", obs.pc); end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < (1 << CW) + 5; i++) begin
      step(0, 0, 1, 1, 0, 0, 3'b000, 32'h200, 32'h0, 0, 0, 1); tick();
    end
    vectors++; if (obs.cb !== SAT || obs.ct !== SAT) begin errors++;
      $display("FAIL sat_cnt got %h/%h want %h/%h", obs.cb, obs.ct, SAT, SAT); end
    vectors++; if (obs.cb !== cur.cb || obs.pc !== cur.pc) begin errors++;
      $display("FAIL sat_model got %h/%h want %h/%h", obs.cb, obs.pc, cur.cb, cur.pc); end
  endtask

  task automatic test_reset_mid_redirect();
    step(1, 0, 1, 0, 1, 0, 3'b000, 32'h300, 32'h40, 0, 0, 0); tick();
    vectors++; if ({obs.redir, obs.fif, obs.fid} !== 3'b111) begin errors++;
      $display("FAIL rst_redir_flush got %b%b%b want 111", obs.redir, obs.fif, obs.fid); end
    vectors++; if (obs.pc !== cur.pc || obs.cb !== cur.cb || obs.ct !== cur.ct) begin errors++;
      $display("FAIL rst_redir_state got %h/%h/%h want %h/%h/%h", obs.pc, obs.cb, obs.ct,
               cur.pc, cur.cb, cur.ct); end
  endtask

  initial begin
    m_pc = RST_PC; m_cb = '0; m_ct = '0;
    rst = 1'b1; stall = 1'b0; valid = 1'b0; is_br = 1'b0; is_jal = 1'b0; is_jalr = 1'b0;
    funct3 = 3'b000; ex_pc = '0; imm = '0; rs1 = '0; less = 1'b0; equal = 1'b0;
    test_reset();
    test_sequential();
    test_blt_taken();
    test_bgeu_not_taken();
    test_jalr_misalign();
    test_stall();
    test_illegal();
    test_valid_low();
    test_back_to_back();
    test_saturation();
    test_reset_mid_redirect();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
